// File: rtl/kronos_result_sched.sv
// kronos_result_sched
//   Result-side scheduler for the kronos coprocessor datapath. Every accepted
//   instruction is tagged and carried through a DP_LAT-deep tag pipeline that
//   runs alongside the fixed-latency datapath. When a tag exits, its fields and
//   dp_result_i are pushed into an in-order result FIFO that drives the X-IF
//   result handshake. A credit counter (in-flight + buffered) provides issue
//   back-pressure, a small FSM tracks rol32_1->rol32_2 chains and a flush/drain
//   sequence.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   issue_valid_i/id/rd     accepted instruction and its X-IF id / destination
//   issue_done_i/cont_i     writeback request / chained intermediate op
//   issue_stall_o           back-pressure to the decoder
//   dp_result_i             datapath result, valid DP_LAT cycles after issue
//   flush_i, flush_done_o   flush request pulse / completion pulse
//   chain_busy_o            chain opened, closing op not yet issued
//   chain_err_o             pulse, cycle after an illegal op inside a chain
//   result_*                X-IF result channel (valid/ready handshake)
module kronos_result_sched #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DP_LAT = 2,
   parameter int unsigned ID_W   = 4,
   parameter int unsigned XLEN   = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            issue_valid_i,
   input  logic [ID_W-1:0] issue_id_i,
   input  logic [4:0]      issue_rd_i,
   input  logic            issue_done_i,
   input  logic            issue_cont_i,
   output logic            issue_stall_o,
   input  logic [XLEN-1:0] dp_result_i,
   input  logic            flush_i,
   output logic            flush_done_o,
   output logic            chain_busy_o,
   output logic            chain_err_o,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [ID_W-1:0] result_id_o,
   output logic [4:0]      result_rd_o,
   output logic [XLEN-1:0] result_data_o,
   output logic            result_we_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, CHAIN, DRAIN} state_e;

   typedef struct packed {
      logic            v;
      logic [ID_W-1:0] id;
      logic [4:0]      rd;
      logic            we;
   } tag_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [4:0]      rd;
      logic            we;
      logic [XLEN-1:0] data;
   } ent_t;

   state_e        state_q;
   logic          chain_err_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] fcnt_q, fcnt_d;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   tag_t          tag_q [DP_LAT];
   tag_t          tag_d;
   ent_t          fifo_q [DEPTH];
   ent_t          push_ent;
   ent_t          head;
   logic          issue_acc, push, pop;

   assign issue_stall_o  = (cnt_q == CW'(DEPTH)) | (state_q == DRAIN);
   assign issue_acc      = issue_valid_i & ~issue_stall_o;
   assign push           = tag_q[DP_LAT-1].v;
   assign result_valid_o = (fcnt_q != '0);
   assign pop            = result_valid_o & result_ready_i;

   assign head           = fifo_q[rd_ptr_q];
   assign result_id_o    = head.id;
   assign result_rd_o    = head.rd;
   assign result_we_o    = head.we;
   assign result_data_o  = head.data;

   assign chain_busy_o   = (state_q == CHAIN);
   assign chain_err_o    = chain_err_q;
   // Credits count in-flight and buffered insns, so cnt==0 in DRAIN means
   // the pipeline and FIFO are both empty.
   assign flush_done_o   = (state_q == DRAIN) && (cnt_q == '0);

   always_comb begin
      tag_d    = '0;
      tag_d.v  = issue_acc;
      tag_d.id = issue_id_i;
      tag_d.rd = issue_rd_i;
      tag_d.we = issue_done_i & ~issue_cont_i;

      push_ent      = '0;
      push_ent.id   = tag_q[DP_LAT-1].id;
      push_ent.rd   = tag_q[DP_LAT-1].rd;
      push_ent.we   = tag_q[DP_LAT-1].we;
      push_ent.data = dp_result_i;

      cnt_d = cnt_q;
      case ({issue_acc, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase

      fcnt_d = fcnt_q;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 1'b1;
         2'b01:   fcnt_d = fcnt_q - 1'b1;
         default: fcnt_d = fcnt_q;
      endcase
   end

   // Tag pipeline, result FIFO and credit counters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DP_LAT; i++) tag_q[i] <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)  fifo_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fcnt_q   <= '0;
         cnt_q    <= '0;
      end else begin
         tag_q[0] <= tag_d;
         for (int unsigned i = 1; i < DP_LAT; i++) tag_q[i] <= tag_q[i-1];
         if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
            wr_ptr_q         <= wr_ptr_q + 1'b1;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         fcnt_q <= fcnt_d;
         cnt_q  <= cnt_d;
      end
   end

   // Chain / flush control. A flush takes priority over a same-cycle issue's
   // chain bookkeeping; that issue is still tagged if it was accepted.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         chain_err_q <= 1'b0;
      end else begin
         chain_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (flush_i)                        state_q <= DRAIN;
               else if (issue_acc && issue_cont_i) state_q <= CHAIN;
            end
            CHAIN: begin
               if (flush_i) begin
                  state_q <= DRAIN;
               end else if (issue_acc) begin
                  if (issue_done_i && !issue_cont_i) state_q     <= IDLE;
                  else                               chain_err_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (cnt_q == '0) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
